// File: rtl/id_pkg.sv
// Shared RV32I decode definitions for the ID stage: opcodes, format one-hots,
// writeback and ALU select codes, the decoded control bundle and its decoder.
package id_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [5:0] FMT_NONE = 6'b000000;
    localparam logic [5:0] FMT_R    = 6'b000001;
    localparam logic [5:0] FMT_I    = 6'b000010;
    localparam logic [5:0] FMT_S    = 6'b000100;
    localparam logic [5:0] FMT_B    = 6'b001000;
    localparam logic [5:0] FMT_U    = 6'b010000;
    localparam logic [5:0] FMT_J    = 6'b100000;

    localparam logic [2:0] WR_ALU    = 3'd0;
    localparam logic [2:0] WR_MEM    = 3'd1;
    localparam logic [2:0] WR_PC4    = 3'd2;
    localparam logic [2:0] WR_IMM    = 3'd3;
    localparam logic [2:0] WR_PC_IMM = 3'd4;

    // ALU op codes line up with funct3 so OP/OP-IMM can pass funct3 straight through.
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLL  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SR   = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    typedef struct packed {
        logic [5:0]  format;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        alu_input_sel;
        logic        alu_sub_sel;
        logic        alu_sign_sel;
        logic        alu_arith_sel;
        logic [2:0]  alu_op_sel;
        logic        jump_type_sel;
        logic        jump_sel;
        logic        dmem_wr_en;
        logic        dmem_rd_en;
        logic        reg_wr_en;
        logic [2:0]  reg_wr_sel;
        logic        halt;
        logic        trap;
        logic [31:0] immed;
    } ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input logic [5:0] fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic uses_rs1(input logic [5:0] fmt);
        return |(fmt & (FMT_R | FMT_I | FMT_S | FMT_B));
    endfunction

    function automatic logic uses_rs2(input logic [5:0] fmt);
        return |(fmt & (FMT_R | FMT_S | FMT_B));
    endfunction

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t      c;
        logic [2:0] f3;
        logic       alt;
        c      = '0;
        f3     = instr[14:12];
        alt    = instr[30];
        c.funct3 = f3;
        c.funct7 = instr[31:25];
        case (instr[6:0])
            OPC_LUI: begin
                c.format = FMT_U; c.alu_input_sel = 1'b1;
                c.reg_wr_en = 1'b1; c.reg_wr_sel = WR_IMM;
            end
            OPC_AUIPC: begin
                c.format = FMT_U; c.alu_input_sel = 1'b1;
                c.reg_wr_en = 1'b1; c.reg_wr_sel = WR_PC_IMM;
            end
            OPC_JAL: begin
                c.format = FMT_J; c.jump_sel = 1'b1;
                c.reg_wr_en = 1'b1; c.reg_wr_sel = WR_PC4;
            end
            OPC_JALR: begin
                c.format = FMT_I; c.jump_sel = 1'b1; c.jump_type_sel = 1'b1;
                c.alu_input_sel = 1'b1; c.reg_wr_en = 1'b1; c.reg_wr_sel = WR_PC4;
            end
            OPC_BRANCH: begin
                // Branches compare by subtraction; BLT/BGE need the signed flavour.
                c.format = FMT_B; c.alu_sub_sel = 1'b1;
                c.alu_sign_sel = f3[2] & ~f3[1];
            end
            OPC_LOAD: begin
                c.format = FMT_I; c.alu_input_sel = 1'b1; c.dmem_rd_en = 1'b1;
                c.reg_wr_en = 1'b1; c.reg_wr_sel = WR_MEM;
            end
            OPC_STORE: begin
                c.format = FMT_S; c.alu_input_sel = 1'b1; c.dmem_wr_en = 1'b1;
            end
            OPC_OP_IMM: begin
                c.format = FMT_I; c.alu_input_sel = 1'b1; c.alu_op_sel = f3;
                c.alu_sign_sel = (f3 == ALU_SLT);
                c.alu_arith_sel = (f3 == ALU_SR) & alt;
                c.reg_wr_en = 1'b1; c.reg_wr_sel = WR_ALU;
            end
            OPC_OP: begin
                c.format = FMT_R; c.alu_op_sel = f3;
                c.alu_sub_sel = (f3 == ALU_ADD) & alt;
                c.alu_sign_sel = (f3 == ALU_SLT);
                c.alu_arith_sel = (f3 == ALU_SR) & alt;
                c.reg_wr_en = 1'b1; c.reg_wr_sel = WR_ALU;
            end
            OPC_MISC_MEM: begin
                c.format = FMT_I;
            end
            OPC_SYSTEM: begin
                c.format = FMT_I;
                c.halt = (f3 == 3'b000) & instr[20];
            end
            default: begin
                c.format = FMT_NONE; c.trap = 1'b1;
            end
        endcase
        c.immed = imm_gen(instr, c.format);
        return c;
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational load-use stall detection and WB->ID bypass selection.
module id_hazard_unit #(
    parameter int AW        = 5,
    parameter int BYPASS_EN = 1,
    parameter int HAZARD_EN = 1
) (
    input  logic          if_valid,
    input  logic          ex_valid,
    input  logic          ex_load,
    input  logic [AW-1:0] ex_rd_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic          use_rs1,
    input  logic          use_rs2,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    output logic          stall,
    output logic          bypass_rs1,
    output logic          bypass_rs2
);

    logic rs1_hit;
    logic rs2_hit;
    logic wb_live;

    assign rs1_hit = use_rs1 && (ex_rd_addr == rs1_addr);
    assign rs2_hit = use_rs2 && (ex_rd_addr == rs2_addr);

    // A load sitting in the bundle cannot feed the instruction behind it in the same cycle.
    assign stall = (HAZARD_EN != 0) && if_valid && ex_valid && ex_load &&
                   (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

    assign wb_live    = (BYPASS_EN != 0) && wb_en && (wb_addr != '0);
    assign bypass_rs1 = wb_live && (wb_addr == rs1_addr);
    assign bypass_rs2 = wb_live && (wb_addr == rs2_addr);

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: one instruction per cycle into a registered bundle, with
// register file, WB bypass, load-use bubble, flush and sticky halt.
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    parameter int HAZARD_EN = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_instr,
    input  logic            i_flush,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [AW-1:0]   o_rs1_addr,
    output logic [AW-1:0]   o_rs2_addr,
    output logic [AW-1:0]   o_rd_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_immed,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic [5:0]      o_format,
    output logic            o_alu_input_sel,
    output logic            o_alu_sub_sel,
    output logic            o_alu_sign_sel,
    output logic            o_alu_arith_sel,
    output logic [2:0]      o_alu_op_sel,
    output logic            o_jump_type_sel,
    output logic            o_jump_sel,
    output logic            o_dmem_wr_en,
    output logic            o_dmem_rd_en,
    output logic            o_reg_wr_en,
    output logic [2:0]      o_reg_wr_sel,
    output logic            o_halt,
    output logic            o_trap,
    output logic            o_halted
);

    import id_pkg::*;

    // Handshakes: a side transfers on a cycle where its valid and ready are both high;
    // valid never waits on ready, and the bundle is frozen while valid is high and ready low.

    ctrl_t           dec;
    ctrl_t           ctrl_q;
    logic            ex_valid_q;
    logic            halted_q;
    logic [AW-1:0]   rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic [XLEN-1:0] rs1_data_q, rs2_data_q;

    logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rf_rd1, rf_rd2, rs1_data, rs2_data;
    logic [XLEN-1:0] rf_q [NREGS];
    logic            stall, bypass_rs1, bypass_rs2;
    logic            accept;

    assign dec      = decode(i_instr);
    assign rs1_addr = i_instr[15 +: AW];
    assign rs2_addr = i_instr[20 +: AW];
    assign rd_addr  = i_instr[7 +: AW];

    // Register file: writes land every cycle regardless of pipeline state; x0 stays zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (i_wb_en && (i_wb_addr != '0)) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    assign rf_rd1 = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
    assign rf_rd2 = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];

    id_hazard_unit #(
        .AW        (AW),
        .BYPASS_EN (BYPASS_EN),
        .HAZARD_EN (HAZARD_EN)
    ) u_hazard (
        .if_valid   (i_if_valid),
        .ex_valid   (ex_valid_q),
        .ex_load    (ctrl_q.dmem_rd_en),
        .ex_rd_addr (rd_addr_q),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .use_rs1    (uses_rs1(dec.format)),
        .use_rs2    (uses_rs2(dec.format)),
        .wb_en      (i_wb_en),
        .wb_addr    (i_wb_addr),
        .stall      (stall),
        .bypass_rs1 (bypass_rs1),
        .bypass_rs2 (bypass_rs2)
    );

    assign rs1_data = bypass_rs1 ? i_wb_data : rf_rd1;
    assign rs2_data = bypass_rs2 ? i_wb_data : rf_rd2;

    assign o_if_ready = !halted_q && !stall && (!ex_valid_q || i_ex_ready);
    assign accept     = i_if_valid && o_if_ready;

    // Flush wins over accept and hold; an empty or drained slot simply goes invalid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            ctrl_q     <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            if (ex_valid_q && i_ex_ready && ctrl_q.halt) halted_q <= 1'b1;
            if (i_flush) begin
                ex_valid_q <= 1'b0;
            end else if (accept) begin
                ex_valid_q <= 1'b1;
                ctrl_q     <= dec;
                rs1_addr_q <= rs1_addr;
                rs2_addr_q <= rs2_addr;
                rd_addr_q  <= rd_addr;
                rs1_data_q <= rs1_data;
                rs2_data_q <= rs2_data;
            end else if (i_ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign o_ex_valid      = ex_valid_q;
    assign o_halted        = halted_q;
    assign o_rs1_addr      = rs1_addr_q;
    assign o_rs2_addr      = rs2_addr_q;
    assign o_rd_addr       = rd_addr_q;
    assign o_rs1_data      = rs1_data_q;
    assign o_rs2_data      = rs2_data_q;
    assign o_immed         = XLEN'($signed(ctrl_q.immed));
    assign o_funct3        = ctrl_q.funct3;
    assign o_funct7        = ctrl_q.funct7;
    assign o_format        = ctrl_q.format;
    assign o_alu_input_sel = ctrl_q.alu_input_sel;
    assign o_alu_sub_sel   = ctrl_q.alu_sub_sel;
    assign o_alu_sign_sel  = ctrl_q.alu_sign_sel;
    assign o_alu_arith_sel = ctrl_q.alu_arith_sel;
    assign o_alu_op_sel    = ctrl_q.alu_op_sel;
    assign o_jump_type_sel = ctrl_q.jump_type_sel;
    assign o_jump_sel      = ctrl_q.jump_sel;
    assign o_dmem_wr_en    = ctrl_q.dmem_wr_en;
    assign o_dmem_rd_en    = ctrl_q.dmem_rd_en;
    assign o_reg_wr_en     = ctrl_q.reg_wr_en;
    assign o_reg_wr_sel    = ctrl_q.reg_wr_sel;
    assign o_halt          = ctrl_q.halt;
    assign o_trap          = ctrl_q.trap;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, streaming, backpressure, load-use,
// bypass, flush, trap and halt, with hand-computed expectations.
module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093;
    localparam logic [31:0] I_ADD_X2_X1   = 32'h0010_8133;
    localparam logic [31:0] I_ADDI_X7_M1  = 32'hFFF0_0393;
    localparam logic [31:0] I_ADDI_X8_3   = 32'h0030_0413;
    localparam logic [31:0] I_LW_X3       = 32'h0000_A183;
    localparam logic [31:0] I_ADD_X4_X3   = 32'h0021_8233;
    localparam logic [31:0] I_LW_X0       = 32'h0000_A003;
    localparam logic [31:0] I_ADD_X4_X0   = 32'h0020_0233;
    localparam logic [31:0] I_ADD_X6_X0   = 32'h0000_0333;
    localparam logic [31:0] I_ADD_X6_X5   = 32'h0052_8333;
    localparam logic [31:0] I_EBREAK      = 32'h0010_0073;
    localparam logic [31:0] I_ILLEGAL     = 32'h0000_007F;

    // clock / reset / stimulus signals
    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid, if_ready, flush, wb_en, ex_valid, ex_ready;
    logic [31:0]     instr;
    logic [AW-1:0]   wb_addr, rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] wb_data, rs1_data, rs2_data, immed;
    logic [2:0]      funct3, alu_op_sel, reg_wr_sel;
    logic [6:0]      funct7;
    logic [5:0]      format;
    logic            alu_input_sel, alu_sub_sel, alu_sign_sel, alu_arith_sel;
    logic            jump_type_sel, jump_sel, dmem_wr_en, dmem_rd_en, reg_wr_en;
    logic            halt, trap, halted;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [XLEN-1:0] exp_q[$];

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .NREGS(32), .BYPASS_EN(1), .HAZARD_EN(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .o_if_ready(if_ready),
        .i_instr(instr), .i_flush(flush), .i_wb_en(wb_en), .i_wb_addr(wb_addr),
        .i_wb_data(wb_data), .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
        .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr), .o_rd_addr(rd_addr),
        .o_rs1_data(rs1_data), .o_rs2_data(rs2_data), .o_immed(immed),
        .o_funct3(funct3), .o_funct7(funct7), .o_format(format),
        .o_alu_input_sel(alu_input_sel), .o_alu_sub_sel(alu_sub_sel),
        .o_alu_sign_sel(alu_sign_sel), .o_alu_arith_sel(alu_arith_sel),
        .o_alu_op_sel(alu_op_sel), .o_jump_type_sel(jump_type_sel), .o_jump_sel(jump_sel),
        .o_dmem_wr_en(dmem_wr_en), .o_dmem_rd_en(dmem_rd_en), .o_reg_wr_en(reg_wr_en),
        .o_reg_wr_sel(reg_wr_sel), .o_halt(halt), .o_trap(trap), .o_halted(halted)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked there too.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; instr = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b0;

        // reset
        cyc(); cyc();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_immed", immed, 0);
        check("rst_format", format, 0);
        check("rst_rs1_data", rs1_data, 0);
        check("rst_reg_wr_en", reg_wr_en, 0);
        rst = 1'b0;
        #1 check("rst_if_ready", if_ready, 1);

        // streaming
        ex_ready = 1'b1; if_valid = 1'b1; instr = I_ADDI_X1_5;
        cyc();
        check("addi_valid", ex_valid, 1);
        check("addi_immed", immed, 5);
        check("addi_format", format, 6'b000010);
        check("addi_rd", rd_addr, 1);
        check("addi_alu_in", alu_input_sel, 1);
        instr = I_ADD_X2_X1;
        #1 check("stream_ready", if_ready, 1);
        cyc();
        check("add_valid", ex_valid, 1);
        check("add_format", format, 6'b000001);
        check("add_rs1", rs1_addr, 1);
        check("add_rs2", rs2_addr, 1);
        check("add_rd", rd_addr, 2);
        check("add_immed", immed, 0);
        check("add_alu_in", alu_input_sel, 0);
        if_valid = 1'b0;
        cyc();
        check("stream_drain", ex_valid, 0);

        // backpressure
        ex_ready = 1'b0; if_valid = 1'b1; instr = I_ADDI_X7_M1;
        exp_q.push_back(32'hFFFF_FFFF);
        cyc();
        instr = I_ADDI_X8_3;
        exp_q.push_back(32'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_hold_valid", ex_valid, 1);
            check("bp_hold_immed", immed, 32'hFFFF_FFFF);
            check("bp_hold_rd", rd_addr, 7);
            check("bp_if_ready", if_ready, 0);
            cyc();
        end
        ex_ready = 1'b1;
        #1 check("bp_release_ready", if_ready, 1);
        check("bp_xfer0", immed, exp_q.pop_front());
        cyc();
        if_valid = 1'b0;
        check("bp_xfer1_valid", ex_valid, 1);
        check("bp_xfer1", immed, exp_q.pop_front());
        check("bp_xfer1_rd", rd_addr, 8);
        cyc();
        check("bp_drain", ex_valid, 0);

        // load-use: one bubble
        if_valid = 1'b1; instr = I_LW_X3;
        cyc();
        instr = I_ADD_X4_X3;
        #1 check("lu_stall", if_ready, 0);
        check("lu_load", dmem_rd_en, 1);
        check("lu_load_sel", reg_wr_sel, 1);
        cyc();
        check("lu_bubble", ex_valid, 0);
        #1 check("lu_ready_after", if_ready, 1);
        cyc();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_rd", rd_addr, 4);
        check("lu_add_rs1", rs1_addr, 3);
        if_valid = 1'b0;
        cyc();

        // load to x0: no bubble
        if_valid = 1'b1; instr = I_LW_X0;
        cyc();
        instr = I_ADD_X4_X0;
        #1 check("lu0_no_stall", if_ready, 1);
        cyc();
        check("lu0_valid", ex_valid, 1);
        check("lu0_rd", rd_addr, 4);
        if_valid = 1'b0;
        cyc();

        // bypass
        if_valid = 1'b1; instr = I_ADD_X6_X0;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        cyc();
        check("byp0_rs1", rs1_data, 0);
        check("byp0_rs2", rs2_data, 0);
        instr = I_ADD_X6_X5; wb_addr = 5'd5;
        cyc();
        check("byp5_rs1", rs1_data, 32'hDEAD_BEEF);
        check("byp5_rs2", rs2_data, 32'hDEAD_BEEF);
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        cyc();
        check("rf5_rs1", rs1_data, 32'hDEAD_BEEF);
        check("rf5_rs2", rs2_data, 32'hDEAD_BEEF);
        if_valid = 1'b0;
        cyc();

        // flush during a stalled hold
        if_valid = 1'b1; instr = I_LW_X3;
        cyc();
        instr = I_ADD_X4_X3; ex_ready = 1'b0; flush = 1'b1;
        #1 check("fl_stall", if_ready, 0);
        cyc();
        check("fl_killed", ex_valid, 0);
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        cyc();
        check("fl_nothing", ex_valid, 0);

        // flush beats accept
        if_valid = 1'b1; instr = I_ADDI_X1_5; flush = 1'b1;
        #1 check("fl_ready_unaffected", if_ready, 1);
        cyc();
        check("fl_no_capture", ex_valid, 0);
        flush = 1'b0; if_valid = 1'b0;
        cyc();

        // trap then halt
        if_valid = 1'b1; instr = I_ILLEGAL;
        cyc();
        check("trap_valid", ex_valid, 1);
        check("trap_flag", trap, 1);
        check("trap_reg_wr", reg_wr_en, 0);
        check("trap_dmem_wr", dmem_wr_en, 0);
        check("trap_dmem_rd", dmem_rd_en, 0);
        check("trap_halt", halt, 0);
        instr = I_EBREAK;
        cyc();
        check("halt_flag", halt, 1);
        check("halt_trap", trap, 0);
        check("halt_not_yet", halted, 0);
        if_valid = 1'b0;
        cyc();
        check("halted_set", halted, 1);
        check("halted_empty", ex_valid, 0);
        if_valid = 1'b1; instr = I_ADDI_X1_5;
        #1 check("halted_ready", if_ready, 0);
        cyc(); cyc();
        check("halted_ready_late", if_ready, 0);
        check("halted_no_issue", ex_valid, 0);

        // reset clears the sticky halt
        rst = 1'b1;
        cyc();
        check("rst2_halted", halted, 0);
        check("rst2_valid", ex_valid, 0);
        rst = 1'b0; if_valid = 1'b0;
        #1 check("rst2_ready", if_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
